// File: rtl/mac_sched_pkg.sv
// Shared types and protocol constants for the MAC frame scheduler.
// The block codes match the XGMII-style stream of the 64-bit frame generator.
package mac_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_EOF = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    localparam logic [7:0] TERMINATE_CODE = 8'hFD;
    localparam logic [7:0] START_CODE     = 8'hFB;
    localparam logic [7:0] STOP_DATA      = 8'h02;
    localparam logic [7:0] NO_INTR        = 8'h00;
    localparam logic [7:0] CTRL_TERM      = 8'h01;

    function automatic logic [7:0] clamp_gap(input logic [7:0] gap, input logic [7:0] min_gap);
        return (gap < min_gap) ? min_gap : gap;
    endfunction

endpackage

// File: rtl/mac_eof_detector.sv
// Combinational end-of-frame match on the generator output: a TERMINATE block has only the
// lane-0 control bit set and 8'hFD in lane 0. A START block (8'hFB) never matches.
module mac_eof_detector
    import mac_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CTRL_WIDTH-1:0] tx_ctrl,
    output logic                  eof
);

    // Only lane 0 carries the terminate code; the upper lanes are don't-care.
    logic unused_upper;
    assign unused_upper = ^tx_data[DATA_WIDTH-1:8];

    assign eof = (tx_ctrl == CTRL_WIDTH'(CTRL_TERM)) && (tx_data[7:0] == TERMINATE_CODE);

endmodule

// File: rtl/mac_frame_scheduler.sv
// Sequences the 64-bit MAC frame generator: start pulses, inter-frame gap, per-frame interrupt
// selection, EOF confirmation and watchdog. Optional statistics ports under MAC_SCHED_STATS_EN.
module mac_frame_scheduler
    import mac_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int CNT_WIDTH      = 16,
    parameter int MIN_GAP        = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [CNT_WIDTH-1:0]  i_cfg_frames,
    input  logic [7:0]            i_cfg_gap,
    input  logic [7:0]            i_cfg_intr_period,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
    output logic                  o_start,
    output logic [7:0]            o_interrupt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt
`ifdef MAC_SCHED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_intr_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_timeout_cnt
`endif
);

    localparam int                WD_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        MIN_GAP_B = 8'(MIN_GAP);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] frames_r;
    logic [7:0]           gap_r, period_r, phase_r, gap_cnt;
    logic [WD_W-1:0]      wd;
    logic                 eof;

    logic                 accept, eof_hit, expire, finish;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [7:0]           launch_period, launch_phase;
    logic                 phase_hit;

    mac_eof_detector #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_eof (
        .tx_data (i_tx_data),
        .tx_ctrl (i_tx_ctrl),
        .eof     (eof)
    );

    assign cnt_inc = sat_inc(o_frame_cnt);

    // The first launch of a run uses the config being accepted; later launches use the latched copy.
    assign launch_period = (state == ST_IDLE) ? i_cfg_intr_period : period_r;
    assign launch_phase  = (state == ST_IDLE) ? 8'd0 : phase_r;
    assign phase_hit     = (launch_period != 8'd0) &&
                           (({1'b0, launch_phase} + 9'd1) == {1'b0, launch_period});

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        eof_hit  = 1'b0;
        expire   = 1'b0;
        finish   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cfg_valid && o_cfg_ready) begin
                    accept   = 1'b1;
                    state_nx = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nx = ST_WAIT_EOF;
            ST_WAIT_EOF: begin
                // EOF takes priority over a watchdog expiry in the same cycle.
                if (eof) begin
                    eof_hit = 1'b1;
                    if (i_abort || ((frames_r != '0) && (cnt_inc == frames_r))) begin
                        finish   = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_GAP;
                    end
                end else if (wd == WD_LAST) begin
                    expire   = 1'b1;
                    finish   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (i_abort) begin
                    finish   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (gap_cnt <= 8'd1) begin
                    state_nx = ST_LAUNCH;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cfg_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_start     <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_interrupt <= NO_INTR;
            o_frame_cnt <= '0;
            frames_r    <= '0;
            gap_r       <= 8'd0;
            period_r    <= 8'd0;
            phase_r     <= 8'd0;
            gap_cnt     <= 8'd0;
            wd          <= '0;
        end else begin
            o_cfg_ready <= (state_nx == ST_IDLE);
            o_busy      <= (state_nx != ST_IDLE);
            o_start     <= (state_nx == ST_LAUNCH);
            o_done      <= finish;
            o_timeout   <= expire;

            if (accept) begin
                frames_r    <= i_cfg_frames;
                gap_r       <= clamp_gap(i_cfg_gap, MIN_GAP_B);
                period_r    <= i_cfg_intr_period;
                o_frame_cnt <= '0;
            end else if (eof_hit) begin
                o_frame_cnt <= cnt_inc;
            end

            if (state_nx == ST_LAUNCH) begin
                o_interrupt <= phase_hit ? STOP_DATA : NO_INTR;
                phase_r     <= phase_hit ? 8'd0 : launch_phase + 8'd1;
            end else if (eof_hit || expire) begin
                o_interrupt <= NO_INTR;
            end

            if (eof_hit)               gap_cnt <= gap_r;
            else if (state == ST_GAP)  gap_cnt <= gap_cnt - 8'd1;

            // Watchdog is zero during the launch cycle and counts every cycle after it.
            if (state_nx == ST_LAUNCH)                              wd <= '0;
            else if ((state == ST_LAUNCH) || (state == ST_WAIT_EOF)) wd <= wd + 1'b1;
        end
    end

`ifdef MAC_SCHED_STATS_EN
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_intr_frame_cnt <= '0;
            o_timeout_cnt    <= '0;
        end else begin
            if (accept)                                     o_intr_frame_cnt <= '0;
            else if (eof_hit && (o_interrupt == STOP_DATA)) o_intr_frame_cnt <= sat_inc(o_intr_frame_cnt);
            // Sticky across runs; only reset clears it.
            if (expire) o_timeout_cnt <= sat_inc(o_timeout_cnt);
        end
    end
`endif

endmodule
